ctl_seq: RTL and testbench
==========================

// Module: ctl_seq
// PURPOSE
//  tiny16 control sequencer; drives every source enable into the 16-bit data bus mux and every bus load.
//  Owns PC, IR, MAR and the Z flag. Runs fetch/decode/execute and waits on memory via a req/ready handshake.
//  Guarantees at most one of alu/mem/reg/ctl_out_en is high in any cycle.
//  Sits upstream of the bus mux and consumes the mux output.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  MEM_TIMEOUT  255       max wait cycles for mem_ready before fault halt (8-bit counter)
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  bus_in       in   16  bus mux output
//  mem_ready    in   1   memory completes current req this cycle
//  alu_zero     in   1   ALU result == 0
//  alu_out_en   out  1   bus source = ALU
//  mem_out_en   out  1   bus source = memory read data
//  reg_out_en   out  1   bus source = register file port B
//  ctl_out_en   out  1   bus source = ctl_out
//  ctl_out      out  16  immediate, {8'h00, IR[7:0]}
//  mem_req      out  1   memory access request
//  mem_we       out  1   write qualifier for mem_req
//  mem_addr     out  16  PC in FETCH, MAR otherwise
//  reg_a_sel    out  4   register port A select (ALU operand A) = IR[11:8]
//  reg_b_sel    out  4   register port B select (bus / ALU operand B)
//  reg_wr_en    out  1   register file loads bus_in at reg_wr_sel
//  reg_wr_sel   out  4   = IR[11:8]
//  alu_op       out  4   = IR[3:0]
//  halted       out  1   in HALT state
//  fault        out  1   illegal opcode or memory timeout; sticky
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=FETCH, PC=RESET_PC, IR=MAR=0, Z=0, wait count=0.
//   - All enables, req, we, halted, fault = 0.
//  IR fields: op=IR[15:12], rd=IR[11:8], rs=IR[7:4], imm8=IR[7:0], fn=IR[3:0].
//  FETCH: mem_req=1, mem_out_en=1, mem_addr=PC.
//   - On mem_ready: IR<=bus_in, PC<=PC+1 (mod 2^16, FFFF wraps to 0000), ->DECODE.
//  DECODE: 1 cycle, no bus enable.
//   - op in {0..7,F} ->EXEC; else fault<=1, ->HALT.
//  EXEC, by op:
//   - 0 NOP: ->FETCH.
//   - 1 LDI: ctl_out_en, reg_wr_en; rd<=imm8 zero-extended; ->FETCH.
//   - 2 MOV: reg_out_en, b_sel=rs, reg_wr_en; ->FETCH.
//   - 3 ALU: alu_out_en, b_sel=rs, reg_wr_en, Z<=alu_zero; ->FETCH.
//   - 4 LD / 5 ST: reg_out_en, b_sel=rs, MAR<=bus_in; ->MEM.
//   - 6 JMP: reg_out_en, b_sel=rs, PC<=bus_in; ->FETCH.
//   - 7 JZ: as JMP when Z=1; else no-op; ->FETCH.
//   - F HLT: ->HALT.
//  MEM: mem_req=1, mem_addr=MAR.
//   - LD: mem_out_en; on mem_ready reg_wr_en; ->FETCH.
//   - ST: mem_we=1, reg_out_en, b_sel=rd; on mem_ready ->FETCH.
//   - Outputs held stable until ready.
//  Wait counter (FETCH/MEM): increments each not-ready cycle, clears on ready or state exit.
//   - Count==MEM_TIMEOUT without ready: fault<=1, ->HALT, mem_req drops next cycle.
//  HALT: all enables/req low, halted=1; left only by reset.
//  Unlisted-state b_sel = rs. ctl_out is combinational from IR; zero enables = bus idle.
//  Reset asserted mid-transaction drops mem_req immediately (async); memory ignores the aborted access.
// STRUCTURE
//  Shared package tiny16_pkg:
//   - opcode localparams OP_NOP..OP_HLT.
//   - state encoding FETCH, DECODE, EXEC, MEM, HALT.
//   - field slice macros/functions.
//  Single module. Next-state/output logic combinational; PC/IR/MAR/Z/state/counter registered.
//  Wait counter inline; no sub-module.
// TESTING
//  1. Reset, mem returns 16'h1305 after 2 wait cycles -> IR=1305, PC=0001, R3<=0005 in EXEC via ctl_out_en.
//  2. Program LDI r1,#0; ALU r1=r1 op r1 with alu_zero=1; JZ r2 (r2=0040) -> Z=1, PC=0040 after JZ EXEC.
//  3. ST r4->[r5] (r5=0100, r4=BEEF) -> MEM cycle mem_addr=0100, mem_we=1, bus=BEEF until ready.
//  4. Fetch opcode 8 -> fault=1, halted=1 after DECODE; no enables thereafter.
//  5. mem_ready never asserted -> fault/halt exactly MEM_TIMEOUT+1 cycles into FETCH.
//  6. rst low during MEM wait -> mem_req=0 same cycle; resume fetch at RESET_PC. Assert enables one-hot-or-zero always.

Source files
------------

// File: rtl/ctl_seq_pkg.sv
// Shared definitions for the tiny16 control sequencer: opcodes, FSM states
// and instruction-field helpers.
package ctl_seq_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_MOV = 4'h2;
   localparam logic [3:0] OP_ALU = 4'h3;
   localparam logic [3:0] OP_LD  = 4'h4;
   localparam logic [3:0] OP_ST  = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_t;

   function automatic logic [3:0] f_op(input logic [15:0] ir);
      return ir[15:12];
   endfunction

   function automatic logic [3:0] f_rd(input logic [15:0] ir);
      return ir[11:8];
   endfunction

   function automatic logic [3:0] f_rs(input logic [15:0] ir);
      return ir[7:4];
   endfunction

   function automatic logic [7:0] f_imm8(input logic [15:0] ir);
      return ir[7:0];
   endfunction

   function automatic logic [3:0] f_fn(input logic [15:0] ir);
      return ir[3:0];
   endfunction

   // Opcodes 8..E are reserved and fault in DECODE.
   function automatic logic op_legal(input logic [3:0] op);
      return (op <= OP_JZ) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/ctl_seq_if.sv
// Bus-side signal bundle of the tiny16 sequencer: bus mux enables, memory
// handshake, register file controls and status.
interface ctl_seq_if;
   import ctl_seq_pkg::*;

   logic [15:0] bus_in;
   logic        mem_ready;
   logic        alu_zero;
   logic        alu_out_en;
   logic        mem_out_en;
   logic        reg_out_en;
   logic        ctl_out_en;
   logic [15:0] ctl_out;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [3:0]  reg_a_sel;
   logic [3:0]  reg_b_sel;
   logic        reg_wr_en;
   logic [3:0]  reg_wr_sel;
   logic [3:0]  alu_op;
   logic        halted;
   logic        fault;

   modport master (
      input  bus_in, mem_ready, alu_zero,
      output alu_out_en, mem_out_en, reg_out_en, ctl_out_en, ctl_out,
             mem_req, mem_we, mem_addr, reg_a_sel, reg_b_sel, reg_wr_en,
             reg_wr_sel, alu_op, halted, fault
   );

   modport slave (
      output bus_in, mem_ready, alu_zero,
      input  alu_out_en, mem_out_en, reg_out_en, ctl_out_en, ctl_out,
             mem_req, mem_we, mem_addr, reg_a_sel, reg_b_sel, reg_wr_en,
             reg_wr_sel, alu_op, halted, fault
   );

endinterface

// File: rtl/ctl_seq.sv
// tiny16 control sequencer: fetch/decode/execute FSM owning PC, IR, MAR and
// the Z flag, driving bus source enables and bus loads, with a bounded wait
// on the memory handshake.
module ctl_seq
   import ctl_seq_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   ctl_seq_if.master  bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t      state, state_n;
   logic [15:0] pc, pc_n;
   logic [15:0] ir, ir_n;
   logic [15:0] mar, mar_n;
   logic        z, z_n;
   logic [7:0]  cnt, cnt_n;
   logic        fault_q, fault_n;
   logic        wait_st;

   assign bus.ctl_out    = {8'h00, f_imm8(ir)};
   assign bus.reg_a_sel  = f_rd(ir);
   assign bus.reg_wr_sel = f_rd(ir);
   assign bus.alu_op     = f_fn(ir);
   assign bus.fault      = fault_q;

   // Next-state, register updates and bus controls; everything idles while reset is low.
   always_comb begin
      state_n        = state;
      pc_n           = pc;
      ir_n           = ir;
      mar_n          = mar;
      z_n            = z;
      cnt_n          = '0;
      fault_n        = fault_q;
      wait_st        = 1'b0;
      bus.alu_out_en = 1'b0;
      bus.mem_out_en = 1'b0;
      bus.reg_out_en = 1'b0;
      bus.ctl_out_en = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.reg_wr_en  = 1'b0;
      bus.reg_b_sel  = f_rs(ir);
      bus.halted     = 1'b0;
      bus.mem_addr   = (state == ST_FETCH) ? pc : mar;
      if (rst) begin
         unique case (state)
            ST_FETCH: begin
               wait_st        = 1'b1;
               bus.mem_req    = 1'b1;
               bus.mem_out_en = 1'b1;
               if (bus.mem_ready) begin
                  ir_n    = bus.bus_in;
                  pc_n    = pc + 16'd1;
                  state_n = ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (op_legal(f_op(ir))) begin
                  state_n = ST_EXEC;
               end else begin
                  fault_n = 1'b1;
                  state_n = ST_HALT;
               end
            end
            ST_EXEC: begin
               state_n = ST_FETCH;
               unique case (f_op(ir))
                  OP_LDI: begin
                     bus.ctl_out_en = 1'b1;
                     bus.reg_wr_en  = 1'b1;
                  end
                  OP_MOV: begin
                     bus.reg_out_en = 1'b1;
                     bus.reg_wr_en  = 1'b1;
                  end
                  OP_ALU: begin
                     bus.alu_out_en = 1'b1;
                     bus.reg_wr_en  = 1'b1;
                     z_n            = bus.alu_zero;
                  end
                  OP_LD, OP_ST: begin
                     bus.reg_out_en = 1'b1;
                     mar_n          = bus.bus_in;
                     state_n        = ST_MEM;
                  end
                  OP_JMP: begin
                     bus.reg_out_en = 1'b1;
                     pc_n           = bus.bus_in;
                  end
                  OP_JZ: begin
                     if (z) begin
                        bus.reg_out_en = 1'b1;
                        pc_n           = bus.bus_in;
                     end
                  end
                  OP_HLT:  state_n = ST_HALT;
                  default: ;
               endcase
            end
            ST_MEM: begin
               wait_st     = 1'b1;
               bus.mem_req = 1'b1;
               if (f_op(ir) == OP_ST) begin
                  bus.mem_we     = 1'b1;
                  bus.reg_out_en = 1'b1;
                  bus.reg_b_sel  = f_rd(ir);
               end else begin
                  bus.mem_out_en = 1'b1;
                  bus.reg_wr_en  = bus.mem_ready;
               end
               if (bus.mem_ready) state_n = ST_FETCH;
            end
            ST_HALT: bus.halted = 1'b1;
            default: state_n = ST_HALT;
         endcase
         // Shared FETCH/MEM wait counter; it defaults to zero so any exit clears it.
         if (wait_st && !bus.mem_ready) begin
            if (cnt == TIMEOUT_CNT) begin
               fault_n = 1'b1;
               state_n = ST_HALT;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
      end
   end

   // Architectural state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         mar     <= '0;
         z       <= 1'b0;
         cnt     <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         ir      <= ir_n;
         mar     <= mar_n;
         z       <= z_n;
         cnt     <= cnt_n;
         fault_q <= fault_n;
      end
   end

endmodule

// File: tb/tb_ctl_seq.sv
// Bench for ctl_seq: a behavioural datapath (memory, register file, ALU, bus
// mux) around the sequencer, checked against an instruction-level model.
module tb_ctl_seq;
   import ctl_seq_pkg::*;

   localparam int unsigned TMO = 255;

   logic clk = 1'b0;
   logic rst = 1'b0;
   ctl_seq_if bus ();

   ctl_seq #(.RESET_PC(16'h0000), .MEM_TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Datapath environment state.
   logic [15:0] env_mem [0:65535];
   logic [15:0] env_reg [0:15];
   // Instruction-level reference model state.
   logic [15:0] m_mem [0:65535];
   logic [15:0] m_reg [0:15];
   logic [15:0] m_pc;
   logic        m_z, m_halt, m_fault, m_pend, m_dwe;
   logic [15:0] m_daddr;
   logic [3:0]  m_drd;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu_f(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
      case (fn[1:0])
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   logic [15:0] alu_res;
   assign alu_res      = alu_f(bus.alu_op, env_reg[bus.reg_a_sel], env_reg[bus.reg_b_sel]);
   assign bus.alu_zero = (alu_res == 16'h0000);
   assign bus.bus_in   = bus.mem_out_en ? env_mem[bus.mem_addr] :
                         bus.alu_out_en ? alu_res :
                         bus.reg_out_en ? env_reg[bus.reg_b_sel] :
                         bus.ctl_out_en ? bus.ctl_out : 16'h0000;

   function automatic logic [5:0] outs_vec();
      return {bus.alu_out_en, bus.mem_out_en, bus.reg_out_en, bus.ctl_out_en, bus.mem_req, bus.reg_wr_en};
   endfunction

   // At most one bus source may be enabled in any cycle.
   always @(negedge clk) begin
      if (rst)
         check("onehot", 32'($countones({bus.alu_out_en, bus.mem_out_en, bus.reg_out_en, bus.ctl_out_en}) <= 1), 32'd1);
   end

   function automatic logic [15:0] rand_instr();
      int unsigned p;
      logic [3:0]  op;
      p = $urandom_range(0, 99);
      if (p < 3)      op = OP_HLT;
      else if (p < 5) op = 4'(8 + $urandom_range(0, 6));
      else            op = 4'($urandom_range(0, 7));
      return {op, 12'($urandom)};
   endfunction

   // Retire one instruction in the model (pc already advanced).
   task automatic model_exec(input logic [15:0] instr);
      logic [3:0]  op, rd, rs;
      logic [15:0] res;
      op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4];
      case (op)
         4'h0: ;
         4'h1: m_reg[rd] = {8'h00, instr[7:0]};
         4'h2: m_reg[rd] = m_reg[rs];
         4'h3: begin
            res = alu_f(instr[3:0], m_reg[rd], m_reg[rs]);
            m_reg[rd] = res;
            m_z = (res == 16'h0000);
         end
         4'h4, 4'h5: begin
            m_pend = 1'b1; m_daddr = m_reg[rs]; m_dwe = (op == 4'h5); m_drd = rd;
         end
         4'h6: m_pc = m_reg[rs];
         4'h7: if (m_z) m_pc = m_reg[rs];
         4'hF: m_halt = 1'b1;
         default: begin m_halt = 1'b1; m_fault = 1'b1; end
      endcase
   endtask

   // A memory access completes this cycle: compare against the model's expectation.
   task automatic handle_txn();
      logic [15:0] instr;
      if (!m_pend) begin
         check("fetch_addr", 32'(bus.mem_addr), 32'(m_pc));
         check("fetch_we", 32'(bus.mem_we), 32'd0);
         for (int i = 0; i < 16; i++) check("reg", 32'(env_reg[i]), 32'(m_reg[i]));
         instr = m_mem[m_pc];
         m_pc  = m_pc + 16'd1;
         model_exec(instr);
      end else begin
         check("data_addr", 32'(bus.mem_addr), 32'(m_daddr));
         check("data_we", 32'(bus.mem_we), 32'(m_dwe));
         if (m_dwe) begin
            check("st_data", 32'(bus.bus_in), 32'(m_reg[m_drd]));
            m_mem[m_daddr] = m_reg[m_drd];
         end else begin
            m_reg[m_drd] = m_mem[m_daddr];
         end
         m_pend = 1'b0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check("rst_outs", 32'({outs_vec(), bus.mem_we, bus.halted, bus.fault}), 32'd0);
   endtask

   task automatic run_program(input int k);
      int  budget, idle, since_halt;
      bit  done, wr_reg, wr_mem;
      logic [3:0]  wr_sel;
      logic [15:0] wr_val, st_addr;
      apply_reset();
      for (int i = 0; i < 65536; i++) env_mem[i] = 16'hF000;
      for (int i = 0; i < 256; i++) env_mem[i] = rand_instr();
      if (k == 0) env_mem[0] = 16'h1305;
      if (k == 1) env_mem[0] = 16'h8123;
      for (int i = 0; i < 65536; i++) m_mem[i] = env_mem[i];
      for (int i = 0; i < 16; i++) begin
         env_reg[i] = 16'($urandom_range(0, 255));
         m_reg[i]   = env_reg[i];
      end
      m_pc = 16'h0000; m_z = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      budget = 0; idle = 0; since_halt = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         bus.mem_ready = ($urandom_range(0, 2) == 0);
         #1;
         wr_reg = 1'b0; wr_mem = 1'b0; wr_sel = '0; wr_val = '0; st_addr = '0;
         if (k >= 2 && m_pend && bus.mem_req && !bus.mem_ready && $urandom_range(0, 9) == 0) begin
            rst = 1'b0;
            #1;
            check("abort_req", 32'(bus.mem_req), 32'd0);
            check("abort_outs", 32'(outs_vec()), 32'd0);
            done = 1'b1;
         end else if (bus.halted) begin
            check("halt_expected", 32'(m_halt), 32'd1);
            check("fault", 32'(bus.fault), 32'(m_fault));
            check("halt_quiet", 32'({outs_vec(), bus.mem_we}), 32'd0);
            done = 1'b1;
         end else begin
            wr_reg = bus.reg_wr_en; wr_sel = bus.reg_wr_sel; wr_val = bus.bus_in;
            wr_mem = bus.mem_req && bus.mem_we && bus.mem_ready; st_addr = bus.mem_addr;
            if (bus.mem_req && bus.mem_ready) begin
               if (m_halt) check("req_after_halt", 32'(bus.mem_req), 32'd0);
               else begin handle_txn(); budget++; end
               idle = 0;
            end else idle++;
            if (m_halt) since_halt++;
            if (since_halt > 4) begin check("halt_timeout", 32'(bus.halted), 32'd1); done = 1'b1; end
            if (idle > 60) begin check("stall_timeout", 32'(idle), 32'd0); done = 1'b1; end
            if (budget >= 120 && !m_pend) done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (wr_reg) env_reg[wr_sel] = wr_val;
         if (wr_mem) env_mem[st_addr] = wr_val;
      end
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 24; k++) run_program(k);
      // Memory never answers: fault exactly MEM_TIMEOUT+1 cycles into FETCH.
      apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (TMO) @(posedge clk);
      @(negedge clk);
      check("tmo_early_halt", 32'(bus.halted), 32'd0);
      check("tmo_early_fault", 32'(bus.fault), 32'd0);
      check("tmo_req_held", 32'(bus.mem_req), 32'd1);
      check("tmo_addr", 32'(bus.mem_addr), 32'h0000);
      @(posedge clk);
      @(negedge clk);
      check("tmo_halt", 32'(bus.halted), 32'd1);
      check("tmo_fault", 32'(bus.fault), 32'd1);
      check("tmo_req_drop", 32'(bus.mem_req), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
